// File: rtl/dram_access_sequencer_if.sv
// rtl/dram_access_sequencer_if.sv - bus bundle between the DRAM access sequencer and its neighbours
interface dram_access_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic [ADDR_WIDTH-1:0] proc_addr;
   logic [DATA_WIDTH-1:0] proc_wdata;
   logic                  proc_wren;
   logic                  proc_done;
   logic                  enable_processor;
   logic [ADDR_WIDTH-1:0] dram_address;
   logic [DATA_WIDTH-1:0] dram_data;
   logic                  dram_wren;
   logic [DATA_WIDTH-1:0] dram_q;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [1:0]            phase;
   logic                  load_done;

   modport master (
      input  rx_data, rx_valid, proc_addr, proc_wdata, proc_wren, proc_done, dram_q, tx_ready,
      output enable_processor, dram_address, dram_data, dram_wren, tx_data, tx_valid, phase, load_done
   );

   modport slave (
      output rx_data, rx_valid, proc_addr, proc_wdata, proc_wren, proc_done, dram_q, tx_ready,
      input  enable_processor, dram_address, dram_data, dram_wren, tx_data, tx_valid, phase, load_done
   );
endinterface

// File: rtl/dram_access_sequencer.sv
// rtl/dram_access_sequencer.sv - single-port DRAM owner: UART load, processor run, UART dump
module dram_access_sequencer #(
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] LOAD_LAST  = 16'hFFFF,
   parameter logic [ADDR_WIDTH-1:0] TX_START   = 16'h0000,
   parameter logic [ADDR_WIDTH-1:0] TX_LAST    = 16'h00FF
) (
   input  logic                   clk,
   input  logic                   reset,
   dram_access_sequencer_if.master bus
);
   localparam logic [2:0] S_LOAD     = 3'd0;
   localparam logic [2:0] S_RUN      = 3'd1;
   localparam logic [2:0] S_TX_READ  = 3'd2;
   localparam logic [2:0] S_TX_LATCH = 3'd3;
   localparam logic [2:0] S_TX_SEND  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
   logic [ADDR_WIDTH-1:0] tx_ptr_q, tx_ptr_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  en_proc_q, en_proc_d;
   logic                  load_done_q, load_done_d;

   logic [ADDR_WIDTH-1:0] mux_addr;
   logic [DATA_WIDTH-1:0] mux_data;
   logic                  mux_wren;
   logic [1:0]            phase_w;

   always_comb begin
      state_d     = state_q;
      load_ptr_d  = load_ptr_q;
      tx_ptr_d    = tx_ptr_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      en_proc_d   = en_proc_q;
      load_done_d = load_done_q;
      case (state_q)
         S_LOAD: begin
            if (bus.rx_valid) begin
               // The final byte lands at LOAD_LAST; the pointer parks there rather than wrapping.
               if (load_ptr_q == LOAD_LAST) begin
                  state_d     = S_RUN;
                  load_done_d = 1'b1;
                  en_proc_d   = 1'b1;
               end else begin
                  load_ptr_d = load_ptr_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            if (bus.proc_done) begin
               state_d   = S_TX_READ;
               en_proc_d = 1'b0;
               tx_ptr_d  = TX_START;
            end
         end
         S_TX_READ: state_d = S_TX_LATCH;
         S_TX_LATCH: begin
            tx_data_d  = bus.dram_q;
            tx_valid_d = 1'b1;
            state_d    = S_TX_SEND;
         end
         S_TX_SEND: begin
            if (tx_valid_q && bus.tx_ready) begin
               tx_valid_d = 1'b0;
               if (tx_ptr_q == TX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  tx_ptr_d = tx_ptr_q + 1'b1;
                  state_d  = S_TX_READ;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      mux_addr = '0;
      mux_data = '0;
      mux_wren = 1'b0;
      phase_w  = 2'd3;
      case (state_q)
         S_LOAD: begin
            mux_addr = load_ptr_q;
            mux_data = bus.rx_data;
            mux_wren = bus.rx_valid;
            phase_w  = 2'd0;
         end
         S_RUN: begin
            mux_addr = bus.proc_addr;
            mux_data = bus.proc_wdata;
            mux_wren = bus.proc_wren;
            phase_w  = 2'd1;
         end
         S_TX_READ, S_TX_LATCH, S_TX_SEND: begin
            mux_addr = tx_ptr_q;
            phase_w  = 2'd2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_LOAD;
         load_ptr_q  <= '0;
         tx_ptr_q    <= TX_START;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         en_proc_q   <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_ptr_q  <= load_ptr_d;
         tx_ptr_q    <= tx_ptr_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         en_proc_q   <= en_proc_d;
         load_done_q <= load_done_d;
      end
   end

   // Write enable is masked during reset so a strobe racing the reset cannot corrupt DRAM.
   assign bus.dram_address     = mux_addr;
   assign bus.dram_data        = mux_data;
   assign bus.dram_wren        = mux_wren & ~reset;
   assign bus.enable_processor = en_proc_q;
   assign bus.tx_data          = tx_data_q;
   assign bus.tx_valid         = tx_valid_q;
   assign bus.phase            = phase_w;
   assign bus.load_done        = load_done_q;
endmodule

// File: tb/tb_dram_access_sequencer.sv
// tb/tb_dram_access_sequencer.sv - randomized self-checking bench for dram_access_sequencer
module tb_dram_access_sequencer;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam logic [15:0] LL = 16'd3;
   localparam logic [15:0] TS = 16'd1;
   localparam logic [15:0] TL = 16'd2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dram_access_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dram_access_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_LAST(LL), .TX_START(TS), .TX_LAST(TL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // Synchronous DRAM: address captured on the edge, data visible the following cycle.
   logic [DW-1:0] dram_mem [0:(1<<AW)-1];
   logic [AW-1:0] rd_addr_q = '0;
   always @(posedge clk) begin
      if (bus.dram_wren) dram_mem[bus.dram_address] <= bus.dram_data;
      rd_addr_q <= bus.dram_address;
   end
   assign bus.dram_q = dram_mem[rd_addr_q];

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] ref_mem [0:3];
   bit skip_reset = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.rx_data = '0; bus.rx_valid = 1'b0;
      bus.proc_addr = '0; bus.proc_wdata = '0; bus.proc_wren = 1'b0; bus.proc_done = 1'b0;
      bus.tx_ready = 1'b0;
   endtask

   task automatic noise_rx();
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic noise_proc();
      bus.proc_wren  = 1'($urandom_range(0, 1));
      bus.proc_done  = 1'($urandom_range(0, 1));
      bus.proc_addr  = 16'($urandom);
      bus.proc_wdata = 8'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      reset = 1'b1;
      bus.rx_valid = 1'b1;
      #1;
      check("rst_wren_gated", bus.dram_wren, 0);
      check("rst_phase", bus.phase, 0);
      check("rst_en", bus.enable_processor, 0);
      check("rst_load_done", bus.load_done, 0);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      @(negedge clk);
      idle();
      reset = 1'b0;
   endtask

   task automatic load_phase();
      logic [7:0] b;
      for (int i = 0; i <= int'(LL); i++) begin
         int gap;
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk); idle(); noise_proc(); #1;
            check("ld_idle_wren", bus.dram_wren, 0);
            check("ld_phase", bus.phase, 0);
            check("ld_en", bus.enable_processor, 0);
         end
         @(negedge clk); idle(); noise_proc();
         b = 8'($urandom);
         bus.rx_valid = 1'b1; bus.rx_data = b;
         #1;
         check("ld_addr", bus.dram_address, i);
         check("ld_wren", bus.dram_wren, 1);
         check("ld_data", bus.dram_data, b);
         check("ld_done_early", bus.load_done, 0);
         ref_mem[i] = b;
      end
      @(negedge clk); idle(); #1;
      check("ld_to_run_phase", bus.phase, 1);
      check("ld_to_run_en", bus.enable_processor, 1);
      check("ld_to_run_done", bus.load_done, 1);
      for (int a = 0; a < 4; a++) check("ld_mem", dram_mem[a], ref_mem[a]);
   endtask

   task automatic run_phase();
      int n;
      logic [1:0] a;
      logic [7:0] d;
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
         @(negedge clk); idle(); noise_rx();
         if ($urandom_range(0, 1) == 1) begin
            a = 2'($urandom); d = 8'($urandom);
            bus.proc_wren = 1'b1; bus.proc_addr = {14'd0, a}; bus.proc_wdata = d;
            ref_mem[a] = d;
         end else begin
            bus.proc_addr = 16'($urandom);
         end
         #1;
         check("run_en", bus.enable_processor, 1);
         check("run_phase", bus.phase, 1);
         check("run_wren", bus.dram_wren, bus.proc_wren);
         if (bus.proc_wren) begin
            check("run_addr", bus.dram_address, bus.proc_addr);
            check("run_data", bus.dram_data, bus.proc_wdata);
         end
      end
      @(negedge clk); idle(); noise_rx();
      a = 2'($urandom); d = 8'($urandom);
      bus.proc_done = 1'b1; bus.proc_wren = 1'b1; bus.proc_addr = {14'd0, a}; bus.proc_wdata = d;
      ref_mem[a] = d;
      #1;
      check("done_wren", bus.dram_wren, 1);
      @(negedge clk); idle(); #1;
      check("run_end_en", bus.enable_processor, 0);
      check("run_end_phase", bus.phase, 2);
      for (int i = 0; i < 4; i++) check("run_mem", dram_mem[i], ref_mem[i]);
   endtask

   // mode 0: ready tied high, 1: random ready, 2: 10-cycle stall on first byte, 3: reset mid-send
   task automatic dump_phase(input int mode);
      logic [7:0] exp_q[$];
      int got, cyc, last_hs, held;
      logic prev_valid, prev_ready;
      logic [7:0] prev_data;
      for (int a = int'(TS); a <= int'(TL); a++) exp_q.push_back(ref_mem[a]);
      got = 0; cyc = 0; last_hs = -1; held = 0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
      while (got < exp_q.size() && cyc < 60) begin
         @(negedge clk); idle(); noise_rx(); noise_proc();
         case (mode)
            0: bus.tx_ready = 1'b1;
            1: bus.tx_ready = 1'($urandom_range(0, 1));
            2: bus.tx_ready = (bus.tx_valid && held < 10) ? 1'b0 : 1'b1;
            default: bus.tx_ready = 1'b0;
         endcase
         if (mode == 3 && bus.tx_valid) begin
            reset = 1'b1;
            #1;
            check("mid_rst_tx_valid", bus.tx_valid, 0);
            check("mid_rst_en", bus.enable_processor, 0);
            check("mid_rst_load_done", bus.load_done, 0);
            check("mid_rst_phase", bus.phase, 0);
            check("mid_rst_wren", bus.dram_wren, 0);
            @(negedge clk); idle(); reset = 1'b0;
            skip_reset = 1'b1;
            return;
         end
         #1;
         check("dump_wren", bus.dram_wren, 0);
         check("dump_phase", bus.phase, 2);
         check("dump_en", bus.enable_processor, 0);
         if (prev_valid && !prev_ready) begin
            check("hold_valid", bus.tx_valid, 1);
            check("hold_data", bus.tx_data, prev_data);
         end
         if (mode == 0 && prev_valid) check("pulse_width", bus.tx_valid, 0);
         if (mode == 2 && bus.tx_valid && !bus.tx_ready) held++;
         if (bus.tx_valid && bus.tx_ready) begin
            check("tx_byte", bus.tx_data, exp_q[got]);
            if (mode == 0 && last_hs >= 0) check("tx_spacing", cyc - last_hs, 3);
            if (mode == 2 && got == 0) check("stall_len", held, 10);
            last_hs = cyc;
            got++;
         end
         prev_valid = bus.tx_valid; prev_ready = bus.tx_ready; prev_data = bus.tx_data;
         cyc++;
      end
      check("dump_count", got, exp_q.size());
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); idle(); noise_rx(); noise_proc(); bus.tx_ready = 1'b1; #1;
         check("done_phase", bus.phase, 3);
         check("done_tx_valid", bus.tx_valid, 0);
         check("done_wren", bus.dram_wren, 0);
      end
   endtask

   initial begin
      idle();
      for (int a = 0; a < 4; a++) dram_mem[a] = '0;
      for (int it = 0; it < 8; it++) begin
         if (!skip_reset) do_reset();
         skip_reset = 1'b0;
         load_phase();
         run_phase();
         dump_phase(it % 4);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dram_access_sequencer.md
Name: dram_access_sequencer

Overview:
- Owns the single DRAM port and sequences it through three phases: UART receiver load, processor run, UART transmitter dump.
- Replaces the direct processor-to-DRAM hookup in the top level.
- Generates the processor enable, the DRAM address/data/write-enable mux, and a byte stream with valid/ready handshake for the transmitter.

Parameters:
- ADDR_WIDTH, 16, DRAM address width
- DATA_WIDTH, 8, DRAM data width
- LOAD_LAST, 16'hFFFF, last DRAM address written during load
- TX_START, 16'h0000, first DRAM address read out during dump
- TX_LAST, 16'h00FF, last DRAM address read out during dump

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_data  in  DATA_WIDTH  byte from UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data valid
- proc_addr  in  ADDR_WIDTH  processor DRAM address
- proc_wdata  in  DATA_WIDTH  processor write data
- proc_wren  in  1  processor write enable
- proc_done  in  1  processor end-of-program (start_Tx) strobe
- enable_processor  out  1  processor run enable
- dram_address  out  ADDR_WIDTH  to DRAM address
- dram_data  out  DATA_WIDTH  to DRAM write data
- dram_wren  out  1  to DRAM wren
- dram_q  in  DATA_WIDTH  DRAM read data
- tx_data  out  DATA_WIDTH  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- phase  out  2  0=LOAD 1=RUN 2=DUMP 3=DONE
- load_done  out  1  high once load completes, until reset

Behaviour:
- DRAM timing: synchronous; address registered on the clk edge, dram_q valid in the following cycle.
- Reset (async, any state): state=LOAD; load_ptr=0; tx_ptr=TX_START.
  - enable_processor, tx_valid, load_done reset to 0; tx_data resets to 0.
  - dram_wren is gated to 0 combinationally while reset is high.
- States: LOAD, RUN, TX_READ, TX_LATCH, TX_SEND, DONE. phase reports 0, 1, 2 for all TX_* states, and 3 respectively.
- DRAM mux: combinational from state.
  - LOAD: address=load_ptr, data=rx_data, wren=rx_valid.
  - RUN: address=proc_addr, data=proc_wdata, wren=proc_wren.
  - TX_*: address=tx_ptr, data=0, wren=0.
  - DONE: address=0, data=0, wren=0.
- LOAD:
  - Each rx_valid writes one byte and increments load_ptr.
  - rx_valid when load_ptr==LOAD_LAST: write occurs; next state RUN; load_done=1; enable_processor=1 from the same edge. load_ptr does not wrap.
- RUN:
  - enable_processor held 1.
  - proc_done sampled high: proc_wren in the same cycle is still honoured; next state TX_READ; enable_processor=0 and tx_ptr=TX_START on that edge.
- TX_READ: DRAM read of tx_ptr issued; next TX_LATCH.
- TX_LATCH: tx_data<=dram_q; tx_valid<=1; next TX_SEND.
- TX_SEND:
  - tx_data and tx_valid hold stable until tx_ready.
  - On tx_valid&&tx_ready: tx_valid<=0. If tx_ptr==TX_LAST, next DONE; else tx_ptr+1 and next TX_READ.
  - Throughput: one byte per 3 cycles minimum.
  - tx_ready while tx_valid=0 is ignored.
- DONE: holds until reset; all strobes ignored.
- Ignored strobes:
  - rx_valid outside LOAD: no write, no state change.
  - proc_done outside RUN: ignored.
  - proc_wren outside RUN: never reaches DRAM.
- TX_START>TX_LAST is illegal; behaviour is unspecified and may be flagged by an assertion.
- Reset mid-dump or mid-run: immediate return to LOAD; no partial byte is presented (tx_valid=0).

Test Plan (LOAD_LAST=3, TX_START=1, TX_LAST=2 unless stated):
- Reset release, then 4 rx_valid strobes with bytes 11,22,33,44 spaced 5 cycles -> DRAM[0..3]=11,22,33,44; load_done and enable_processor rise on the edge after the 4th strobe; phase=1.
- In RUN, proc writes 0x5A to addr 2 concurrent with proc_done -> DRAM[2]=5A; enable_processor=0 the next cycle; phase=2.
- Dump with tx_ready tied 1 -> tx bytes 22 then 5A, each tx_valid pulse exactly one cycle, 3 cycles apart; then phase=3.
- Dump with tx_ready held 0 for 10 cycles -> tx_valid=1 and tx_data=22 stable all 10 cycles; advances only after tx_ready=1.
- rx_valid during RUN/DUMP and proc_wren during LOAD/DUMP -> no DRAM write (dram_wren=0), state unchanged.
- Assert reset for 1 cycle mid-TX_SEND -> tx_valid, enable_processor, load_done all 0 immediately; phase=0; next load restarts at address 0.
